// File: rtl/sram_dp_port_ctrl_if.sv
// Request/response bus between the datapath and sram_dp_port_ctrl.
// The datapath is the master; the controller is the slave.
interface sram_dp_port_ctrl_if #(
  parameter int BITS       = 64,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_valid, wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BITS-1:0]       wr_data;
  logic                  rd_valid, rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rsp_valid, rsp_ready;
  logic [BITS-1:0]       rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sram_dp_port_ctrl.sv
// Valid/ready front end for a dual-port SRAM macro: writes on port 1, reads on port 0,
// with read data returned through a credit-protected FIFO. Option macro: SRAM_DP_PORT_CTRL_FWD_EN.
module sram_dp_port_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
)(
  input  logic                  clk,
  input  logic                  rst,
  sram_dp_port_ctrl_if.slave    bus,
  output logic                  ram_rw0_ce,
  output logic                  ram_rw0_we,
  output logic [ADDR_WIDTH-1:0] ram_rw0_addr,
  output logic [BITS-1:0]       ram_rw0_wd,
  input  logic [BITS-1:0]       ram_rw0_rd,
  output logic                  ram_rw1_ce,
  output logic                  ram_rw1_we,
  output logic [ADDR_WIDTH-1:0] ram_rw1_addr,
  output logic [BITS-1:0]       ram_rw1_wd
);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0]   pending, count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [BITS-1:0] fifo [RSP_DEPTH];
  logic            rd_acc, wr_acc, push, pop, collide, stall, infl_q;
  logic [BITS-1:0] push_data;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign collide      = bus.rd_valid & bus.wr_valid & (bus.rd_addr == bus.wr_addr);
  assign bus.wr_ready = ~rst;
  assign bus.rd_ready = ~rst & (pending < CW'(RSP_DEPTH)) & ~stall;
  assign wr_acc       = bus.wr_valid & bus.wr_ready;
  assign rd_acc       = bus.rd_valid & bus.rd_ready;

  // Addresses/data are gated by the enables so every macro pin idles at 0.
  assign ram_rw1_ce   = wr_acc;
  assign ram_rw1_we   = wr_acc;
  assign ram_rw1_addr = wr_acc ? bus.wr_addr : '0;
  assign ram_rw1_wd   = wr_acc ? bus.wr_data : '0;
  assign ram_rw0_we   = 1'b0;
  assign ram_rw0_wd   = '0;
  assign ram_rw0_addr = ram_rw0_ce ? bus.rd_addr : '0;

`ifdef SRAM_DP_PORT_CTRL_FWD_EN
  logic            fwd_q;
  logic [BITS-1:0] fwd_data_q;

  // A colliding read skips the macro and takes the write data one cycle later.
  assign stall      = 1'b0;
  assign ram_rw0_ce = rd_acc & ~collide;
  assign push_data  = fwd_q ? fwd_data_q : ram_rw0_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q <= rd_acc & collide;
      if (rd_acc & collide) fwd_data_q <= bus.wr_data;
    end
  end
`else
  assign stall      = collide;
  assign ram_rw0_ce = rd_acc;
  assign push_data  = ram_rw0_rd;
`endif

  assign push          = infl_q;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_data  = fifo[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_q  <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
    end else begin
      infl_q <= rd_acc;
      if (push) begin
        fifo[wr_ptr] <= push_data;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Credits cover both in-flight reads and FIFO occupancy.
      case ({rd_acc, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CW'(RSP_DEPTH)));
  a_wr_range: assert property (@(posedge clk) disable iff (rst)
    wr_acc |-> (32'(bus.wr_addr) < WORD_DEPTH));
  a_rd_range: assert property (@(posedge clk) disable iff (rst)
    rd_acc |-> (32'(bus.rd_addr) < WORD_DEPTH));
endmodule

// File: tb/tb_sram_dp_port_ctrl.sv
// Scoreboard bench for sram_dp_port_ctrl: a behavioural SRAM macro, a word-array reference
// model of memory contents, and a monitor that checks responses in order.
module tb_sram_dp_port_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_dp_port_ctrl_if #(.BITS(64), .ADDR_WIDTH(8)) bus();

  logic        ram_rw0_ce, ram_rw0_we, ram_rw1_ce, ram_rw1_we;
  logic [7:0]  ram_rw0_addr, ram_rw1_addr;
  logic [63:0] ram_rw0_wd, ram_rw1_wd;
  logic [63:0] ram_rw0_rd = '0;

  sram_dp_port_ctrl #(.BITS(64), .WORD_DEPTH(256), .ADDR_WIDTH(8), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_rw0_ce(ram_rw0_ce), .ram_rw0_we(ram_rw0_we), .ram_rw0_addr(ram_rw0_addr),
    .ram_rw0_wd(ram_rw0_wd), .ram_rw0_rd(ram_rw0_rd),
    .ram_rw1_ce(ram_rw1_ce), .ram_rw1_we(ram_rw1_we), .ram_rw1_addr(ram_rw1_addr),
    .ram_rw1_wd(ram_rw1_wd)
  );

  // SRAM macro model: synchronous write, registered read.
  logic [63:0] sram [256] = '{default: '0};
  always @(posedge clk) begin
    if (ram_rw1_ce && ram_rw1_we) sram[ram_rw1_addr] <= ram_rw1_wd;
    if (ram_rw0_ce) ram_rw0_rd <= sram[ram_rw0_addr];
  end

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_ce = 0, n_rsp = 0, n_rd_acc = 0;
  logic [63:0] ref_mem [256] = '{default: '0};
  logic [63:0] exp_q [$];
  int          acc_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus side: every accepted read pushes its expected data, taken from the
  // memory contents seen at acceptance (a same-cycle write to that address counts).
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
    end else begin
      if (bus.rd_valid && bus.rd_ready) begin
        e = (bus.wr_valid && bus.wr_ready && bus.wr_addr == bus.rd_addr) ? bus.wr_data
                                                                         : ref_mem[bus.rd_addr];
        exp_q.push_back(e);
        acc_cyc_q.push_back(cyc);
        n_rd_acc++;
      end
      if (bus.wr_valid && bus.wr_ready) ref_mem[bus.wr_addr] = bus.wr_data;
      if (ram_rw0_ce) n_ce++;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    int acc;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_unexpected: got %h expected no response", bus.rsp_data);
      end else begin
        chk("rsp_data", bus.rsp_data, exp_q.pop_front());
        acc = acc_cyc_q.pop_front();
        chk("rsp_lat_min", 64'(cyc - acc >= 2), 64'd1);
      end
      n_rsp++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, a0, c0, drops, vcnt, found;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h22; bus.wr_data = 64'h1234;
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h22; bus.rsp_ready = 1'b0;

    // Reset state, with requests driven to prove readies are gated.
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_ram_ctl", 64'({ram_rw0_ce, ram_rw0_we, ram_rw1_ce, ram_rw1_we}), 64'd0);
    chk("rst_ram_addr", 64'({ram_rw0_addr, ram_rw1_addr}), 64'd0);
    chk("rst_ram_wd", ram_rw0_wd | ram_rw1_wd, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.rsp_ready = 1'b1;

    // Write then read one cycle later: 2-cycle latency, single port-0 access.
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h05; bus.wr_data = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    bus.wr_valid = 1'b0; c0 = n_ce;
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h05;
    @(negedge clk);
    chk("wr_rd_ready", 64'(bus.rd_ready), 64'd1);
    @(posedge clk); #1; bus.rd_valid = 1'b0;
    @(negedge clk); chk("lat_plus1_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk); chk("lat_plus2_valid", 64'(bus.rsp_valid), 64'd1);
    chk("lat_plus2_data", bus.rsp_data, 64'hDEAD_BEEF_0000_0001);
    repeat (3) @(negedge clk);
    chk("ce_pulses", 64'(n_ce - c0), 64'd1);

    // Back-to-back: fill memory, then stream 256 reads.
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1;
      bus.wr_valid = 1'b1; bus.wr_addr = 8'(a); bus.wr_data = 64'(a);
    end
    r0 = n_rsp; drops = 0; vcnt = 0;
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1;
      bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 8'(a);
      @(negedge clk);
      if (!bus.rd_ready) drops++;
      if (bus.rsp_valid) vcnt++;
    end
    @(posedge clk); #1; bus.rd_valid = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.rsp_valid) vcnt++; end
    repeat (3) @(negedge clk);
    chk("b2b_rd_ready_drops", 64'(drops), 64'd0);
    chk("b2b_rsp_cycles", 64'(vcnt), 64'd256);
    chk("b2b_rsp_count", 64'(n_rsp - r0), 64'd256);

    // Backpressure: only RSP_DEPTH reads accepted while rsp_ready is low.
    @(posedge clk); #1; bus.rsp_ready = 1'b0; a0 = n_rd_acc;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.rd_valid = 1'b1; bus.rd_addr = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    chk("bp_accepted", 64'(n_rd_acc - a0), 64'd4);
    chk("bp_rd_ready_low", 64'(bus.rd_ready), 64'd0);
    @(posedge clk); #1;
    bus.rd_valid = 1'b0; bus.rsp_ready = 1'b1; r0 = n_rsp;
    repeat (6) @(negedge clk);
    chk("bp_rsp_count", 64'(n_rsp - r0), 64'd4);
    chk("bp_rd_ready_back", 64'(bus.rd_ready), 64'd1);

    // Same-address collision.
    @(posedge clk); #1;
    bus.wr_valid = 1'b1; bus.wr_addr = 8'h3C; bus.wr_data = {16{4'hA}};
    bus.rd_valid = 1'b1; bus.rd_addr = 8'h3C;
    t0 = cyc + 1;
    @(negedge clk);
    t0 = cyc;
    chk("col_rw0_ce", 64'(ram_rw0_ce), 64'd0);
`ifdef SRAM_DP_PORT_CTRL_FWD_EN
    chk("col_rd_ready", 64'(bus.rd_ready), 64'd1);
    @(posedge clk); #1; bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
`else
    chk("col_rd_ready", 64'(bus.rd_ready), 64'd0);
    @(posedge clk); #1; bus.wr_valid = 1'b0;
    @(negedge clk); chk("col_retry_ready", 64'(bus.rd_ready), 64'd1);
    @(posedge clk); #1; bus.rd_valid = 1'b0;
`endif
    found = -1;
    for (int i = 0; i < 10 && found < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.rsp_valid) begin
        found = cyc - t0;
        chk("col_rsp_data", bus.rsp_data, {16{4'hA}});
      end
    end
`ifdef SRAM_DP_PORT_CTRL_FWD_EN
    chk("col_rsp_latency", 64'(found), 64'd2);
`else
    chk("col_rsp_latency", 64'(found), 64'd3);
`endif
    repeat (3) @(negedge clk);

    // Randomised mix over a small address window: collisions, FIFO wrap, backpressure.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.wr_valid  = 1'($urandom_range(0, 1));
      bus.wr_addr   = 8'($urandom_range(8'h38, 8'h3F));
      bus.wr_data   = {$urandom, $urandom};
      bus.rd_valid  = 1'($urandom_range(0, 1));
      bus.rd_addr   = 8'($urandom_range(8'h38, 8'h3F));
      bus.rsp_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || bus.rsp_valid); i++) @(negedge clk);
    @(negedge clk);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_rsp_idle", 64'(bus.rsp_valid), 64'd0);

    // Reset with reads in flight: they are discarded.
    @(posedge clk); #1; bus.rsp_ready = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 8'h10;
    @(posedge clk); #1; bus.rd_addr = 8'h11;
    @(posedge clk); #1; bus.rd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_rd_ready", 64'(bus.rd_ready), 64'd0);
    @(posedge clk); #1; rst = 1'b0; bus.rsp_ready = 1'b1; r0 = n_rsp;
    @(negedge clk); chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1; bus.rd_valid = 1'b1; bus.rd_addr = 8'h10;
    @(posedge clk); #1; bus.rd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_rsp_count", 64'(n_rsp - r0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
